// File: rtl/mm_pkg.sv
// Shared types and constants for the handshaked memory stage.
package mm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } mm_state_e;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W,
    SZ_D
  } mem_size_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;

  function automatic int unsigned size_bytes(input mem_size_e sz);
    case (sz)
      SZ_B:    return 1;
      SZ_H:    return 2;
      SZ_W:    return 4;
      default: return 8;
    endcase
  endfunction

endpackage

// File: rtl/mm_lane_align.sv
// Lane alignment: store shift and byte enables, misalignment check,
// and load extraction with sign/zero extension.
module mm_lane_align
  import mm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  localparam int unsigned BE_W = DATA_WIDTH / 8,
  localparam int unsigned OFF_W = $clog2(DATA_WIDTH / 8)
) (
  input  logic [OFF_W-1:0]      st_offset,
  input  logic [2:0]            st_funct3,
  input  logic [DATA_WIDTH-1:0] st_data,
  input  logic [OFF_W-1:0]      ld_offset,
  input  logic [2:0]            ld_funct3,
  input  logic [DATA_WIDTH-1:0] ld_data,
  output logic [BE_W-1:0]       be_c,
  output logic [DATA_WIDTH-1:0] wdata_c,
  output logic [DATA_WIDTH-1:0] load_c,
  output logic                  misaligned_c
);

  mem_size_e             st_size;
  mem_size_e             ld_size;
  int unsigned           st_n;
  int unsigned           st_off;
  int unsigned           ld_bits;
  logic [DATA_WIDTH-1:0] ld_shift;
  logic [DATA_WIDTH-1:0] ld_mask;
  logic [DATA_WIDTH-1:0] ld_top;

  assign st_size = mem_size_e'(st_funct3[1:0]);
  assign ld_size = mem_size_e'(ld_funct3[1:0]);

  // Outgoing access: legality, byte enables and lane-shifted store data
  always_comb begin
    st_n   = size_bytes(st_size);
    st_off = 32'(st_offset);
    misaligned_c = ((st_size == SZ_D) && (DATA_WIDTH == 32)) ||
                   ((st_off & (st_n - 1)) != 0);
    be_c = '0;
    for (int unsigned i = 0; i < BE_W; i++) begin
      be_c[i] = (i >= st_off) && (i < st_off + st_n);
    end
    wdata_c = st_data << {st_offset, 3'b000};
  end

  // Returning load: shift lane down, keep size bits, extend from the top kept bit
  always_comb begin
    ld_bits = 8 * size_bytes(ld_size);
    if (ld_bits > DATA_WIDTH) ld_bits = DATA_WIDTH;
    ld_shift = ld_data >> {ld_offset, 3'b000};
    ld_mask  = {DATA_WIDTH{1'b1}} >> (DATA_WIDTH - ld_bits);
    ld_top   = DATA_WIDTH'(1) << (ld_bits - 1);
    load_c   = ld_shift & ld_mask;
    if (!ld_funct3[2] && ((ld_shift & ld_top) != '0)) begin
      load_c = load_c | ~ld_mask;
    end
  end

endmodule

// File: rtl/mm_stage_hs.sv
// Handshaked memory stage between EX/MEM and MEM/WB over a req/gnt/rvalid bus.
// Optional bus timeout abort is enabled by defining MM_TIMEOUT_EN.
module mm_stage_hs
  import mm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_alu_result,
  input  logic [DATA_WIDTH-1:0]   in_write_data,
  input  logic [4:0]              in_rd,
  input  logic                    in_mem_read,
  input  logic                    in_mem_write,
  input  logic [2:0]              in_funct3,
  input  logic                    in_reg_write,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  input  logic                    mem_gnt,
  input  logic                    mem_rvalid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    out_valid,
  output logic [DATA_WIDTH-1:0]   out_result,
  output logic [4:0]              out_rd,
  output logic                    out_reg_write,
  output logic                    out_misaligned,
  output logic                    out_timeout
);

  localparam int unsigned BE_W  = DATA_WIDTH / 8;
  localparam int unsigned OFF_W = $clog2(BE_W);

  mm_state_e             state_q, state_d;
  logic [4:0]            rd_q, rd_d;
  logic                  reg_write_q, reg_write_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [OFF_W-1:0]      offset_q, offset_d;
  logic [DATA_WIDTH-1:0] alu_q, alu_d;

  logic                  in_ready_d, mem_req_d, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_d;
  logic [BE_W-1:0]       mem_be_d;
  logic                  out_valid_d, out_reg_write_d, out_misaligned_d, out_timeout_d;
  logic [DATA_WIDTH-1:0] out_result_d;
  logic [4:0]            out_rd_d;

  logic                  accept_c, mem_op_c, misaligned_c, tmo_hit_c;
  logic [BE_W-1:0]       be_c;
  logic [DATA_WIDTH-1:0] wdata_c, load_c;

  assign accept_c = in_valid && in_ready;
  assign mem_op_c = in_mem_read || in_mem_write;

  mm_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .st_offset    (in_alu_result[OFF_W-1:0]),
    .st_funct3    (in_funct3),
    .st_data      (in_write_data),
    .ld_offset    (offset_q),
    .ld_funct3    (funct3_q),
    .ld_data      (mem_rdata),
    .be_c         (be_c),
    .wdata_c      (wdata_c),
    .load_c       (load_c),
    .misaligned_c (misaligned_c)
  );

`ifdef MM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

  assign tmo_hit_c = (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Held at zero while idle, so it starts from zero on REQ entry
  always_comb begin
    tmo_cnt_d = '0;
    if (state_q != IDLE) tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmo_cnt_q <= '0;
    else        tmo_cnt_q <= tmo_cnt_d;
  end
`else
  // No abort path: the stage waits for the bus indefinitely
  assign tmo_hit_c = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

  // Next-state and next-output logic
  always_comb begin
    state_d          = state_q;
    rd_d             = rd_q;
    reg_write_d      = reg_write_q;
    funct3_d         = funct3_q;
    offset_d         = offset_q;
    alu_d            = alu_q;
    mem_req_d        = 1'b0;
    mem_we_d         = mem_we;
    mem_addr_d       = mem_addr;
    mem_wdata_d      = mem_wdata;
    mem_be_d         = mem_be;
    out_valid_d      = 1'b0;
    out_result_d     = out_result;
    out_rd_d         = out_rd;
    out_reg_write_d  = 1'b0;
    out_misaligned_d = 1'b0;
    out_timeout_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          if (!mem_op_c) begin
            out_valid_d     = 1'b1;
            out_result_d    = in_alu_result;
            out_rd_d        = in_rd;
            out_reg_write_d = in_reg_write;
          end else if (misaligned_c) begin
            out_valid_d      = 1'b1;
            out_misaligned_d = 1'b1;
            out_result_d     = in_alu_result;
            out_rd_d         = in_rd;
          end else begin
            state_d     = REQ;
            mem_req_d   = 1'b1;
            mem_we_d    = in_mem_write;
            mem_addr_d  = ADDR_WIDTH'(in_alu_result);
            mem_wdata_d = wdata_c;
            mem_be_d    = be_c;
            rd_d        = in_rd;
            reg_write_d = in_reg_write;
            funct3_d    = in_funct3;
            offset_d    = in_alu_result[OFF_W-1:0];
            alu_d       = in_alu_result;
          end
        end
      end
      REQ: begin
        if (mem_gnt) begin
          if (mem_we) begin
            state_d      = IDLE;
            out_valid_d  = 1'b1;
            out_result_d = alu_q;
            out_rd_d     = rd_q;
          end else begin
            state_d = WAIT;
          end
        end else if (tmo_hit_c) begin
          state_d       = IDLE;
          out_valid_d   = 1'b1;
          out_timeout_d = 1'b1;
          out_result_d  = alu_q;
          out_rd_d      = rd_q;
        end else begin
          mem_req_d = 1'b1;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          state_d         = IDLE;
          out_valid_d     = 1'b1;
          out_result_d    = load_c;
          out_rd_d        = rd_q;
          out_reg_write_d = reg_write_q;
        end else if (tmo_hit_c) begin
          state_d       = IDLE;
          out_valid_d   = 1'b1;
          out_timeout_d = 1'b1;
          out_result_d  = alu_q;
          out_rd_d      = rd_q;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      rd_q           <= '0;
      reg_write_q    <= 1'b0;
      funct3_q       <= '0;
      offset_q       <= '0;
      alu_q          <= '0;
      in_ready       <= 1'b0;
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      mem_be         <= '0;
      out_valid      <= 1'b0;
      out_result     <= '0;
      out_rd         <= '0;
      out_reg_write  <= 1'b0;
      out_misaligned <= 1'b0;
      out_timeout    <= 1'b0;
    end else begin
      state_q        <= state_d;
      rd_q           <= rd_d;
      reg_write_q    <= reg_write_d;
      funct3_q       <= funct3_d;
      offset_q       <= offset_d;
      alu_q          <= alu_d;
      in_ready       <= in_ready_d;
      mem_req        <= mem_req_d;
      mem_we         <= mem_we_d;
      mem_addr       <= mem_addr_d;
      mem_wdata      <= mem_wdata_d;
      mem_be         <= mem_be_d;
      out_valid      <= out_valid_d;
      out_result     <= out_result_d;
      out_rd         <= out_rd_d;
      out_reg_write  <= out_reg_write_d;
      out_misaligned <= out_misaligned_d;
      out_timeout    <= out_timeout_d;
    end
  end

endmodule

// File: doc/mm_stage_hs.md
Name: mm_stage_hs

Overview:
- Parametrised, handshaked successor to the single-cycle memory stage.
- Sits between the EX/MEM and MEM/WB pipeline registers and issues sized loads and stores (byte/half/word, plus double when DATA_WIDTH=64) over a req/gnt/rvalid memory bus.
- Stalls upstream via in_ready, generates byte enables and store-lane alignment, and sign/zero-extends load data.
- Flags misaligned accesses without issuing them.

Parameters:
DATA_WIDTH, 32, datapath width; legal values 32 or 64
ADDR_WIDTH, 32, memory address width
TIMEOUT_CYCLES, 256, cycles in REQ+WAIT before abort (used only with MM_TIMEOUT_EN)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
in_valid  in  1  EX/MEM entry valid
in_ready  out  1  stage can accept an entry
in_alu_result  in  DATA_WIDTH  ALU result / effective address
in_write_data  in  DATA_WIDTH  store data, LSB-aligned
in_rd  in  5  destination register
in_mem_read  in  1  load
in_mem_write  in  1  store
in_funct3  in  3  RISC-V size/sign code
in_reg_write  in  1  writes rd
mem_req  out  1  bus request
mem_we  out  1  1=store
mem_addr  out  ADDR_WIDTH  access address
mem_wdata  out  DATA_WIDTH  lane-aligned store data
mem_be  out  DATA_WIDTH/8  byte enables
mem_gnt  in  1  request accepted
mem_rvalid  in  1  load data valid
mem_rdata  in  DATA_WIDTH  load data
out_valid  out  1  one-cycle MEM/WB result strobe
out_result  out  DATA_WIDTH  extended load data or ALU result
out_rd  out  5  destination register
out_reg_write  out  1  writeback enable
out_misaligned  out  1  misaligned/illegal-size access
out_timeout  out  1  bus timeout abort; tied 0 without macro

Behaviour:
- Reset: all outputs 0, state IDLE, in_ready=1 after reset release.
- States:
  - IDLE: in_ready=1.
  - REQ: mem_req=1; addr/we/wdata/be held stable until gnt.
  - WAIT: load awaiting rvalid.
- Accept when in_valid&&in_ready. in_mem_read and in_mem_write both set -> treated as store.
- Non-memory entry: out_valid next cycle with out_result=in_alu_result, rd and reg_write passed through; state stays IDLE (one entry per cycle throughput).
- Size codes:
  - funct3[1:0]: 00=B, 01=H, 10=W, 11=D.
  - funct3[2]=1 -> zero-extend load.
  - D when DATA_WIDTH=32 is illegal.
- Misaligned: address not a multiple of the access size, or illegal size.
  - No bus request.
  - out_valid next cycle with out_misaligned=1, out_reg_write=0, out_result=address.
- Aligned access: next cycle state REQ.
  - mem_addr = address with lane bits kept.
  - mem_be = size mask shifted by the lane offset.
  - mem_wdata = store data shifted left by offset*8.
- Store: on gnt, return to IDLE and assert out_valid the following cycle with out_reg_write=0.
- Load: on gnt go to WAIT. On rvalid:
  - shift rdata right by offset*8, truncate to size, sign/zero-extend;
  - register it as out_result; out_valid next cycle; return to IDLE.
- rvalid is sampled only in WAIT and ignored in IDLE/REQ; memory returns data at least one cycle after gnt.
- Latency: load accepted at N, gnt at N+1, rvalid at N+2 -> out_valid at N+3. Store with gnt at N+1 -> out_valid at N+2.
- Async reset mid-transaction: mem_req drops immediately, state IDLE, no out_valid; late rvalid is ignored.

Optional Feature:
- Macro MM_TIMEOUT_EN.
- Defined:
  - counter clears on entering REQ and increments each REQ/WAIT cycle;
  - when it reaches TIMEOUT_CYCLES-1 without completion: drop mem_req, return to IDLE, out_valid next cycle with out_timeout=1, out_reg_write=0;
  - late gnt/rvalid is ignored.
- Undefined: no counter, out_timeout=0, stage waits indefinitely.

Decomposition:
- Package mm_pkg:
  - mm_state_e (IDLE, REQ, WAIT);
  - mem_size_e (B, H, W, D);
  - funct3 constants (LB..LWU, SB..SD);
  - function size_bytes().
- Sub-module mm_lane_align, combinational, holding:
  - store shift/byte-enable generation;
  - load extract/sign-extend;
  - misalignment check.
  Instantiated once.

Test Plan:
- ALU op, in_alu_result=0x1234 -> out_valid at N+1, out_result=0x1234, no mem_req.
- SB addr 0x1003, data 0xAB -> mem_be=4'b1000, mem_wdata=0xAB000000; gnt delayed 3 cycles -> mem_req/addr stable throughout, in_ready=0, out_valid one cycle after gnt.
- LH addr 0x2002, rdata=0x8001xxxx -> out_result=0xFFFF8001. LHU same -> 0x00008001.
- LW addr 0x3002 -> no mem_req, out_misaligned=1, out_reg_write=0. LD with DATA_WIDTH=32 -> same flag.
- rst_n low in WAIT, then rvalid pulse after release -> mem_req=0, no out_valid, state IDLE.
- MM_TIMEOUT_EN, TIMEOUT_CYCLES=8, gnt never asserted -> out_valid with out_timeout=1 exactly 8 cycles after REQ entry.
